// File: rtl/pipe_demux_pkg.sv
// pipe_demux_pkg: shared constants and types for the 1-to-2 registered demux.
// Optional accepted-word counters are enabled by defining PIPE_DEMUX_CNT_EN.
package pipe_demux_pkg;

  // payload width
  localparam int DATA_W   = 16;
  // accepted-word counter width
  localparam int CNT_W    = 16;
  // number of destinations
  localparam int NUM_DEST = 2;

  // destination indices, matching the value of the select bit
  localparam bit DEST0 = 1'b0;
  localparam bit DEST1 = 1'b1;

  // one producer-side request: destination plus payload
  typedef struct packed {
    logic              sel;
    logic [DATA_W-1:0] data;
  } dmx_req_t;

endpackage

// File: rtl/pipe_demux_out_slot.sv
// out_slot: one-entry valid/ready register feeding a single consumer.
// The slot is full while it holds an undelivered word. A load in the same
// cycle as a drain replaces the word and keeps the slot full, so one word
// per cycle can flow through with the consumer ready.
module out_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic         ready,
  output logic         full,
  output logic [W-1:0] data
);

  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_drain;

  assign w_drain = r_full && ready;

  // occupancy: flush wins, then load (also covers drain+load), then drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_full <= 1'b0;
    else if (flush)   r_full <= 1'b0;
    else if (load)    r_full <= 1'b1;
    else if (w_drain) r_full <= 1'b0;
  end

  // payload: captured only on load, so it stays stable while the slot waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_data <= '0;
    else if (load) r_data <= ld_data;
  end

  assign full = r_full;
  assign data = r_data;

endmodule

// File: rtl/pipe_demux.sv
// pipe_demux: registered 1-to-2 demultiplexer with valid/ready on all sides.
// Each destination owns an out_slot, so a stalled consumer only blocks words
// addressed to it. Optional per-destination accept counters (count0/count1)
// are built when PIPE_DEMUX_CNT_EN is defined.
module pipe_demux
  import pipe_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              select,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data
`ifdef PIPE_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1
`endif
);

  dmx_req_t                            w_req;
  logic [NUM_DEST-1:0]                 w_full;
  logic [NUM_DEST-1:0]                 w_load;
  logic [NUM_DEST-1:0]                 w_oready;
  logic [NUM_DEST-1:0][DATA_W-1:0]     w_data;
  logic                                w_sel_full;
  logic                                w_sel_rdy;
  logic                                w_accept;

  assign w_req.sel  = select;
  assign w_req.data = in_data;

  assign w_oready[DEST0] = out0_ready;
  assign w_oready[DEST1] = out1_ready;

  // in_ready looks only at the addressed slot, never at in_valid
  assign w_sel_full = w_full[w_req.sel];
  assign w_sel_rdy  = w_oready[w_req.sel];
  assign in_ready   = !flush && (!w_sel_full || w_sel_rdy);
  assign w_accept   = in_valid && in_ready;

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
    assign w_load[g] = w_accept && (int'(w_req.sel) == g);

    out_slot #(.W(DATA_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .load    (w_load[g]),
      .ld_data (w_req.data),
      .ready   (w_oready[g]),
      .full    (w_full[g]),
      .data    (w_data[g])
    );
  end

  assign out0_valid = w_full[DEST0];
  assign out0_data  = w_data[DEST0];
  assign out1_valid = w_full[DEST1];
  assign out1_data  = w_data[DEST1];

`ifdef PIPE_DEMUX_CNT_EN
  logic [NUM_DEST-1:0][CNT_W-1:0] r_cnt;

  // accepted-word counters: free-running wrap, untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++)
        if (w_load[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
    end
  end

  assign count0 = r_cnt[DEST0];
  assign count1 = r_cnt[DEST1];
`endif

endmodule

// File: tb/tb_pipe_demux.sv
// tb_pipe_demux: table-driven cycle vectors with a per-destination scoreboard,
// plus hand-written async-reset and (with PIPE_DEMUX_CNT_EN) counter sequences.
module tb_pipe_demux;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, select, out0_ready, out1_ready;
  logic [15:0] in_data;
  logic        in_ready, out0_valid, out1_valid;
  logic [15:0] out0_data, out1_data;
`ifdef PIPE_DEMUX_CNT_EN
  logic [15:0] count0, count1;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  typedef struct {
    logic        iv;
    logic        sel;
    logic [15:0] dat;
    logic        r0;
    logic        r1;
    logic        fl;
    logic        e_rdy;
    logic        e_v0;
    logic        e_v1;
  } vec_t;

  vec_t tbl[$];

  pipe_demux dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .select     (select),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef PIPE_DEMUX_CNT_EN
    ,
    .count0     (count0),
    .count1     (count1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic sel, input logic [15:0] d,
                     input logic r0, input logic r1, input logic fl,
                     input logic erdy, input logic ev0, input logic ev1);
    vec_t v;
    v.iv = iv; v.sel = sel; v.dat = d; v.r0 = r0; v.r1 = r1; v.fl = fl;
    v.e_rdy = erdy; v.e_v0 = ev0; v.e_v1 = ev1;
    tbl.push_back(v);
  endtask

  task automatic sb_check(input int i, input int dest, input logic vld,
                          input logic rdy, input logic [15:0] dat);
    if (!vld) return;
    if (dest == 0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL r%0d out0 unexpected word %0h (scoreboard empty)", i, dat);
      end else begin
        chk($sformatf("r%0d out0_data", i), 32'(dat), 32'(q0[0]));
        if (rdy) void'(q0.pop_front());
      end
    end else begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL r%0d out1 unexpected word %0h (scoreboard empty)", i, dat);
      end else begin
        chk($sformatf("r%0d out1_data", i), 32'(dat), 32'(q1[0]));
        if (rdy) void'(q1.pop_front());
      end
    end
  endtask

  task automatic run_row(input int i, input vec_t v);
    in_valid = v.iv; select = v.sel; in_data = v.dat;
    out0_ready = v.r0; out1_ready = v.r1; flush = v.fl;
    @(negedge clk);
    chk($sformatf("r%0d in_ready", i),   32'(in_ready),   32'(v.e_rdy));
    chk($sformatf("r%0d out0_valid", i), 32'(out0_valid), 32'(v.e_v0));
    chk($sformatf("r%0d out1_valid", i), 32'(out1_valid), 32'(v.e_v1));
    sb_check(i, 0, out0_valid, v.r0, out0_data);
    sb_check(i, 1, out1_valid, v.r1, out1_data);
    if (v.fl) begin
      q0.delete();
      q1.delete();
    end
    if (v.iv && v.e_rdy) begin
      if (v.sel) q1.push_back(v.dat);
      else       q0.push_back(v.dat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // iv sel data r0 r1 fl | rdy v0 v1
    add(1, 0, 16'h1234, 1, 1, 0, 1, 0, 0);  // to out0
    add(1, 1, 16'hABCD, 1, 1, 0, 1, 1, 0);  // to out1, 1234 delivered
    add(0, 0, 16'h0000, 1, 1, 0, 1, 0, 1);  // ABCD delivered
    add(1, 0, 16'h1111, 0, 1, 0, 1, 0, 0);  // park 1111 in slot0
    add(1, 0, 16'h5555, 0, 1, 0, 0, 1, 0);  // slot0 blocked
    add(1, 1, 16'h6666, 0, 1, 0, 1, 1, 0);  // out1 still open
    add(0, 1, 16'h0000, 0, 1, 0, 1, 1, 1);  // 6666 out, 1111 held
    add(0, 0, 16'h0000, 1, 1, 0, 1, 1, 0);  // 1111 drains
    for (int k = 1; k <= 8; k++)            // bubble-free stream to out1
      add(1, 1, 16'(k), 1, 1, 0, 1, 0, (k > 1));
    add(0, 1, 16'h0000, 1, 1, 0, 1, 0, 1);
    add(0, 0, 16'h0000, 1, 1, 0, 1, 0, 0);
    add(1, 0, 16'hA000, 1, 1, 0, 1, 0, 0);  // alternating select
    add(1, 1, 16'hB000, 1, 1, 0, 1, 1, 0);
    add(1, 0, 16'hA001, 1, 1, 0, 1, 0, 1);
    add(1, 1, 16'hB001, 1, 1, 0, 1, 1, 0);
    add(0, 0, 16'h0000, 1, 1, 0, 1, 0, 1);
    add(1, 0, 16'hC0C0, 0, 0, 0, 1, 0, 0);  // fill both slots
    add(1, 1, 16'hD0D0, 0, 0, 0, 1, 1, 0);
    add(0, 1, 16'h0000, 0, 0, 0, 0, 1, 1);  // in_ready low without in_valid
    add(1, 0, 16'hEEEE, 1, 0, 1, 0, 1, 1);  // flush blocks accept
    add(0, 0, 16'h0000, 1, 1, 0, 1, 0, 0);  // both empty, EEEE lost
    add(1, 1, 16'h7777, 1, 1, 0, 1, 0, 0);
    add(0, 1, 16'h0000, 1, 1, 1, 0, 0, 1);  // flush + drain same cycle
    add(0, 0, 16'h0000, 1, 1, 0, 1, 0, 0);

    rst_n = 1'b0; flush = 0; in_valid = 0; select = 0; in_data = '0;
    out0_ready = 0; out1_ready = 0;
    #1;
    chk("rst out0_valid", 32'(out0_valid), 32'd0);
    chk("rst out1_valid", 32'(out1_valid), 32'd0);
    chk("rst out0_data",  32'(out0_data),  32'd0);
    chk("rst out1_data",  32'(out1_data),  32'd0);
    chk("rst in_ready",   32'(in_ready),   32'd1);
`ifdef PIPE_DEMUX_CNT_EN
    chk("rst count0", 32'(count0), 32'd0);
    chk("rst count1", 32'(count1), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle in_ready", 32'(in_ready), 32'd1);

    foreach (tbl[i]) run_row(i, tbl[i]);
    chk("final q0 empty", 32'(q0.size()), 32'd0);
    chk("final q1 empty", 32'(q1.size()), 32'd0);

    // async reset with both slots occupied
    in_valid = 1; select = 0; in_data = 16'h4242; out0_ready = 0; out1_ready = 0;
    @(posedge clk); #1;
    select = 1; in_data = 16'h4343;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre-rst out0_valid", 32'(out0_valid), 32'd1);
    chk("pre-rst out1_data",  32'(out1_data),  32'h4343);
    #2 rst_n = 1'b0;
    #1;
    chk("async out0_valid", 32'(out0_valid), 32'd0);
    chk("async out1_valid", 32'(out1_valid), 32'd0);
    chk("async out0_data",  32'(out0_data),  32'd0);
    chk("async out1_data",  32'(out1_data),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef PIPE_DEMUX_CNT_EN
    // two words to dest 1, then 0xFFFE+3 words to dest 0 -> count0 wraps to 1
    in_valid = 1; select = 1; out0_ready = 1; out1_ready = 1; in_data = 16'h0101;
    repeat (2) @(posedge clk);
    #1 select = 0;
    repeat (32'hFFFE + 3) @(posedge clk);
    #1;
    chk("cnt count0 wrap", 32'(count0), 32'h0001);
    chk("cnt count1",      32'(count1), 32'h0002);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("cnt count0 after flush", 32'(count0), 32'h0001);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("cnt async count0",     32'(count0),     32'd0);
    chk("cnt async count1",     32'(count1),     32'd0);
    chk("cnt async out0_valid", 32'(out0_valid), 32'd0);
    in_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
